aes_key_mem: RTL and testbench



---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_key_mem_if.sv | 12 +
 rtl/aes_sbox.sv | 27 ++
 rtl/aes_key_mem.sv | 115 +++++++++++
 tb/tb_aes_key_mem.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-expansion FSM states and the rcon update.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;
    localparam logic [3:0] AES128_ROUNDS   = 4'd10;
    localparam logic [3:0] AES256_ROUNDS   = 4'd14;

    typedef enum logic {
        StIdle,
        StGenerate
    } ctrl_state_e;

    // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] next_rcon(input logic [7:0] rcon);
        return {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_mem_if.sv
// Key-memory bus: key load/start from the controller, round-key read port.
interface aes_key_mem_if;
    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    modport master (output key, keylen, init, round, input round_key, ready);
    modport slave  (input key, keylen, init, round, output round_key, ready);
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to the four bytes of a word in parallel.
module aes_sbox (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            word_o[8*g +: 8] = sub_byte(word_i[8*g +: 8]);
        end
    end
endmodule

// File: rtl/aes_key_mem.sv
// AES-128/256 key expansion: one round key per cycle into a 15-entry memory,
// read back combinationally by round index.
module aes_key_mem
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    aes_key_mem_if.slave bus
);
    ctrl_state_e  state_q, state_d;
    logic [255:0] key_q, key_d;
    logic         keylen_q, keylen_d;
    logic [3:0]   ctr_q, ctr_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         ready_q, ready_d;
    logic [127:0] rk_q [15];
    logic [127:0] rk_d [15];

    logic [127:0] prev_rk, prev2_rk, base_rk, new_rk;
    logic [31:0]  sbox_in, sbox_out, tmp_w, w0, w1, w2, w3;
    logic         is_256, use_rot, from_key, last;

    aes_sbox u_sbox (
        .word_i (sbox_in),
        .word_o (sbox_out)
    );

    always_comb begin
        prev_rk  = '0;
        prev2_rk = '0;
        bus.round_key = '0;
        for (int i = 0; i < 15; i++) begin
            if (ctr_q - 4'd1 == 4'(i)) prev_rk = rk_q[i];
            if (ctr_q - 4'd2 == 4'(i)) prev2_rk = rk_q[i];
            if (bus.round == 4'(i)) bus.round_key = rk_q[i];
        end
    end

    assign bus.ready = ready_q;

    always_comb begin
        is_256   = (keylen_q == AES_256_BIT_KEY);
        // AES-256 odd rounds take SubWord only; everything else rotates and adds rcon.
        use_rot  = !is_256 || !ctr_q[0];
        from_key = (ctr_q == 4'd0) || (is_256 && ctr_q == 4'd1);
        last     = ctr_q == (is_256 ? AES256_ROUNDS : AES128_ROUNDS);
        sbox_in  = use_rot ? {prev_rk[23:0], prev_rk[31:24]} : prev_rk[31:0];
        tmp_w    = use_rot ? (sbox_out ^ {rcon_q, 24'h0}) : sbox_out;
        base_rk  = is_256 ? prev2_rk : prev_rk;
        w0       = base_rk[127:96] ^ tmp_w;
        w1       = base_rk[95:64] ^ w0;
        w2       = base_rk[63:32] ^ w1;
        w3       = base_rk[31:0] ^ w2;
        if (ctr_q == 4'd0) begin
            new_rk = key_q[255:128];
        end else if (from_key) begin
            new_rk = key_q[127:0];
        end else begin
            new_rk = {w0, w1, w2, w3};
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        keylen_d = keylen_q;
        ctr_d    = ctr_q;
        rcon_d   = rcon_q;
        ready_d  = ready_q;
        rk_d     = rk_q;
        unique case (state_q)
            StIdle: begin
                if (bus.init) begin
                    key_d    = bus.key;
                    keylen_d = bus.keylen;
                    ctr_d    = 4'd0;
                    rcon_d   = 8'h01;
                    ready_d  = 1'b0;
                    state_d  = StGenerate;
                end
            end
            StGenerate: begin
                for (int i = 0; i < 15; i++) begin
                    if (ctr_q == 4'(i)) rk_d[i] = new_rk;
                end
                ctr_d = ctr_q + 4'd1;
                if (!from_key && use_rot) rcon_d = next_rcon(rcon_q);
                if (last) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            key_q    <= '0;
            keylen_q <= 1'b0;
            ctr_q    <= 4'd0;
            rcon_q   <= 8'h01;
            ready_q  <= 1'b1;
            for (int i = 0; i < 15; i++) rk_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            ctr_q    <= ctr_d;
            rcon_q   <= rcon_d;
            ready_q  <= ready_d;
            for (int i = 0; i < 15; i++) rk_q[i] <= rk_d[i];
        end
    end
endmodule

// File: tb/tb_aes_key_mem.sv
// Directed bench for aes_key_mem using FIPS-197 key-expansion vectors.
module tb_aes_key_mem;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    aes_key_mem_if bus ();

    aes_key_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K128A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K128B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] JUNK = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] r, output logic [127:0] v);
        bus.round = r;
        #1;
        v = bus.round_key;
    endtask

    // Pulse init and count cycles with ready low; bounded at 40.
    task automatic run(input logic [255:0] k, input logic kl, output int n);
        @(negedge clk);
        bus.key    = k;
        bus.keylen = kl;
        bus.init   = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        n = 0;
        while (bus.ready === 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [127:0] v;
    int           n;

    initial begin
        reset      = 1'b1;
        bus.key    = '0;
        bus.keylen = 1'b0;
        bus.init   = 1'b0;
        bus.round  = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("reset_ready", 128'(bus.ready), 128'd1);
        rd(4'd0, v);  chk("reset_rk0", v, '0);
        rd(4'd14, v); chk("reset_rk14", v, '0);

        // AES-128, FIPS-197 C.1 key; low half must be ignored.
        run({K128A, JUNK}, 1'b0, n);
        chk("a128_busy_cycles", 128'(n), 128'd11);
        rd(4'd0, v);  chk("a128_rk0", v, K128A);
        rd(4'd1, v);  chk("a128_rk1", v, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        rd(4'd10, v); chk("a128_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd(4'd11, v); chk("a128_rk11_untouched", v, '0);
        rd(4'd15, v); chk("a128_rk15", v, '0);

        run({K128B, 128'h0}, 1'b0, n);
        chk("b128_busy_cycles", 128'(n), 128'd11);
        rd(4'd1, v);  chk("b128_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd10, v); chk("b128_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(K256, 1'b1, n);
        chk("a256_busy_cycles", 128'(n), 128'd15);
        rd(4'd0, v);  chk("a256_rk0", v, K256[255:128]);
        rd(4'd1, v);  chk("a256_rk1", v, K256[127:0]);
        rd(4'd2, v);  chk("a256_rk2", v, 128'ha573c29fa176c498a97fce93a572c09c);
        rd(4'd14, v); chk("a256_rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd(4'd15, v); chk("a256_rk15", v, '0);

        // Busy init with a changed key and keylen must be ignored.
        @(negedge clk);
        bus.key    = {K128A, JUNK};
        bus.keylen = 1'b0;
        bus.init   = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        n = 0;
        while (bus.ready === 1'b0 && n < 40) begin
            n++;
            bus.init = (n == 5);
            if (n == 5) begin
                bus.key    = K256;
                bus.keylen = 1'b1;
            end
            @(negedge clk);
        end
        bus.init = 1'b0;
        chk("busy_cycles", 128'(n), 128'd11);
        rd(4'd1, v);  chk("busy_rk1", v, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        rd(4'd10, v); chk("busy_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd(4'd14, v); chk("busy_rk14_kept", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Reset four cycles into an AES-256 run.
        @(negedge clk);
        bus.key    = K256;
        bus.keylen = 1'b1;
        bus.init   = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        chk("abort_ready_low", 128'(bus.ready), 128'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 128'(bus.ready), 128'd1);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), v);
            chk($sformatf("abort_rk%0d", i), v, '0);
        end

        run(K256, 1'b1, n);
        chk("rerun_busy_cycles", 128'(n), 128'd15);
        rd(4'd0, v);  chk("rerun_rk0", v, K256[255:128]);
        rd(4'd14, v); chk("rerun_rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
